// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_arb_pkg
// Description : Shared encodings for the memory port arbiter: FSM states,
//               transaction owner, and the data word returned on a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

  localparam logic [31:0] ARB_ERR_RDATA = 32'hDEADBEEF;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_ctr
// Description : Saturating up-counter. Counts inc pulses up to MAX and holds
//               there; clr returns it to zero (clr wins over inc). sat is
//               high while the count equals MAX.
// Ports       : clk  in  clock, posedge
//               rst  in  asynchronous reset, active-high
//               inc  in  count one event
//               clr  in  clear count
//               sat  out count has reached MAX
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sat = (r_cnt == c_max);

endmodule : arb_starve_ctr
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between the instruction fetch unit
//               and the load/store unit. One transaction outstanding at a
//               time: IDLE (arbitrate/accept) -> REQ (valid/ready to memory)
//               -> RESP (wait for response, route it to the owner).
//               LSU wins ties until IFU has waited through STARVE_MAX LSU
//               grants, then IFU is forced next.
// Ports       : clk, rst                 clock / async active-high reset
//               ifu_req_*/ifu_resp_*     IFU read-only requester
//               lsu_req_*/lsu_resp_*     LSU load/store requester
//               resp_rdata               shared response data (0 when idle)
//               mem_req_* / mem_addr ..  registered memory request
//               mem_resp_valid/mem_rdata memory response
// Config      : MEM_TIMEOUT_EN - when defined, a transaction that waits
//               TIMEOUT_CYCLES cycles in REQ/RESP is terminated with an
//               error response carrying ARB_ERR_RDATA.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_resp_valid,
  output logic                lsu_resp_err,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  // Elaboration-time guard against unusable configurations.
  if (STARVE_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_port_arbiter: STARVE_MAX and TIMEOUT_CYCLES must be >= 1");
  end

  arb_state_t r_state;
  arb_state_t w_next;
  arb_owner_t r_owner;

  logic w_accept;
  logic w_grant_lsu;
  logic w_resp_fire;
  logic w_resp_err;
  logic w_timeout;
  logic w_starve_sat;

  // --------------------------------------------------------------------------
  // Starvation counter: counts LSU grants taken while IFU was waiting.
  // --------------------------------------------------------------------------
  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk (clk),
    .rst (rst),
    .inc (w_accept && w_grant_lsu && ifu_req_valid),
    .clr (w_accept && !w_grant_lsu),
    .sat (w_starve_sat)
  );

  // --------------------------------------------------------------------------
  // Optional per-transaction wait counter.
  // --------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      r_wait_cnt <= '0;
    end else if ((r_state == REQ || r_state == RESP) && (r_wait_cnt != c_wait_last)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Counter holds the number of completed wait cycles, so matching
  // TIMEOUT_CYCLES-1 means the current cycle is the TIMEOUT_CYCLES-th one.
  assign w_timeout = (r_wait_cnt == c_wait_last);
`else
  assign w_timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state, arbitration and response qualification
  // --------------------------------------------------------------------------
  always_comb begin
    w_next        = r_state;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    w_grant_lsu   = 1'b0;
    w_accept      = 1'b0;
    w_resp_fire   = 1'b0;
    w_resp_err    = 1'b0;

    case (r_state)
      IDLE: begin
        // LSU wins unless IFU is waiting and has been passed over too often.
        w_grant_lsu = lsu_req_valid && !(ifu_req_valid && w_starve_sat);
        if (w_grant_lsu) begin
          lsu_req_ready = 1'b1;
        end else if (ifu_req_valid) begin
          ifu_req_ready = 1'b1;
        end
        w_accept = (lsu_req_valid && lsu_req_ready) || (ifu_req_valid && ifu_req_ready);
        if (w_accept) begin
          w_next = REQ;
        end
      end

      REQ: begin
        // A response arriving here is stale/early and is dropped.
        if (w_timeout) begin
          w_resp_fire = 1'b1;
          w_resp_err  = 1'b1;
          w_next      = IDLE;
        end else if (mem_req_ready) begin
          w_next = RESP;
        end
      end

      RESP: begin
        // A real response beats a simultaneous timeout.
        if (mem_resp_valid) begin
          w_resp_fire = 1'b1;
          w_next      = IDLE;
        end else if (w_timeout) begin
          w_resp_fire = 1'b1;
          w_resp_err  = 1'b1;
          w_next      = IDLE;
        end
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Owner and registered memory request
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner       <= OWN_IFU;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
    end else if (w_accept) begin
      mem_req_valid <= 1'b1;
      if (w_grant_lsu) begin
        r_owner   <= OWN_LSU;
        mem_addr  <= lsu_addr;
        mem_wen   <= lsu_wen;
        mem_wdata <= lsu_wdata;
        mem_wstrb <= lsu_wstrb;
      end else begin
        r_owner   <= OWN_IFU;
        mem_addr  <= ifu_addr;
        mem_wen   <= 1'b0;
        mem_wdata <= '0;
        mem_wstrb <= {STRB_W{1'b0}};
      end
    end else if (r_state == REQ && (mem_req_ready || w_timeout)) begin
      mem_req_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Response routing
  // --------------------------------------------------------------------------
  assign ifu_resp_valid = w_resp_fire && (r_owner == OWN_IFU);
  assign lsu_resp_valid = w_resp_fire && (r_owner == OWN_LSU);
  assign ifu_resp_err   = w_resp_err  && (r_owner == OWN_IFU);
  assign lsu_resp_err   = w_resp_err  && (r_owner == OWN_LSU);

  always_comb begin
    resp_rdata = '0;
    if (w_resp_fire) begin
      resp_rdata = w_resp_err ? DATA_W'(ARB_ERR_RDATA) : mem_rdata;
    end
  end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. Inputs
//               change 1 ns after the rising edge; outputs are sampled 2 ns
//               after the rising edge. Timeout scenario is included only
//               when MEM_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_resp_valid;
  logic        ifu_resp_err;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wstrb = '0;
  logic        lsu_resp_valid;
  logic        lsu_resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .STARVE_MAX     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_err   (ifu_resp_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wstrb      (lsu_wstrb),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_err   (lsu_resp_err),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    #1;
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr",      mem_addr, 0);
    chk("rst_mem_wen",       mem_wen, 0);
    chk("rst_mem_wdata",     mem_wdata, 0);
    chk("rst_mem_wstrb",     mem_wstrb, 0);
    chk("rst_resp_rdata",    resp_rdata, 0);
    tick();
    rst = 1'b0;
    tick();

    // ---------------- 1: IFU-only read ----------------
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    #1;
    chk("t1_ifu_ready", ifu_req_ready, 1);
    chk("t1_lsu_ready", lsu_req_ready, 0);
    tick();
    ifu_req_valid = 1'b0;
    #1;
    chk("t1_mem_valid", mem_req_valid, 1);
    chk("t1_mem_addr",  mem_addr, 32'h8000_0000);
    chk("t1_mem_wen",   mem_wen, 0);
    tick();
    #1;
    chk("t1_resp_dropped_valid", mem_req_valid, 0);
    chk("t1_no_early_resp",      ifu_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hCAFE_F00D;
    #1;
    chk("t1_ifu_resp",   ifu_resp_valid, 1);
    chk("t1_lsu_resp",   lsu_resp_valid, 0);
    chk("t1_rdata",      resp_rdata, 32'hCAFE_F00D);
    chk("t1_ifu_err",    ifu_resp_err, 0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("t1_resp_cleared", ifu_resp_valid, 0);
    chk("t1_rdata_zero",   resp_rdata, 0);

    // ---------------- 2: tie, LSU store first ----------------
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0004;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'h1234_5678;
    lsu_wstrb     = 4'hF;
    #1;
    chk("t2_lsu_ready", lsu_req_ready, 1);
    chk("t2_ifu_ready", ifu_req_ready, 0);
    tick();
    lsu_req_valid = 1'b0;
    #1;
    chk("t2_mem_wen",    mem_wen, 1);
    chk("t2_mem_addr",   mem_addr, 32'h8000_1000);
    chk("t2_mem_wdata",  mem_wdata, 32'h1234_5678);
    chk("t2_mem_wstrb",  mem_wstrb, 4'hF);
    chk("t2_req_no_ifu", ifu_req_ready, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1111_1111;
    #1;
    chk("t2_lsu_resp",   lsu_resp_valid, 1);
    chk("t2_ifu_noresp", ifu_resp_valid, 0);
    chk("t2_resp_no_ifu_ready", ifu_req_ready, 0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("t2_ifu_granted", ifu_req_ready, 1);
    tick();
    ifu_req_valid = 1'b0;
    #1;
    chk("t2_ifu_addr",  mem_addr, 32'h8000_0004);
    chk("t2_ifu_wen",   mem_wen, 0);
    chk("t2_ifu_wstrb", mem_wstrb, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_ABCD;
    #1;
    chk("t2_ifu_resp",  ifu_resp_valid, 1);
    chk("t2_ifu_rdata", resp_rdata, 32'h0000_ABCD);
    tick();
    mem_resp_valid = 1'b0;

    // ---------------- 3: starvation rotation ----------------
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0008;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_2000;
    lsu_wen       = 1'b0;
    for (int g = 0; g < 10; g++) begin
      automatic logic exp_lsu = ((g % 5) != 4);
      #1;
      chk($sformatf("t3_lsu_ready_%0d", g), lsu_req_ready, exp_lsu);
      chk($sformatf("t3_ifu_ready_%0d", g), ifu_req_ready, !exp_lsu);
      tick();
      tick();
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'(g);
      #1;
      chk($sformatf("t3_lsu_resp_%0d", g), lsu_resp_valid, exp_lsu);
      tick();
      mem_resp_valid = 1'b0;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick();

    // ---------------- 4: memory back-pressure ----------------
    mem_req_ready  = 1'b0;
    lsu_req_valid  = 1'b1;
    lsu_addr       = 32'h8000_3000;
    lsu_wen        = 1'b1;
    lsu_wdata      = 32'hA5A5_A5A5;
    lsu_wstrb      = 4'h3;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h7777_7777;
    #1;
    chk("t4_stale_idle_resp", lsu_resp_valid | ifu_resp_valid, 0);
    chk("t4_lsu_ready",       lsu_req_ready, 1);
    tick();
    mem_resp_valid = 1'b0;
    ifu_req_valid  = 1'b1;
    lsu_addr       = 32'h8000_4444;
    lsu_wdata      = 32'h0;
    for (int i = 0; i < 10; i++) begin
      mem_resp_valid = (i == 5);
      #1;
      chk($sformatf("t4_valid_%0d", i), mem_req_valid, 1);
      chk($sformatf("t4_addr_%0d", i),  mem_addr, 32'h8000_3000);
      chk($sformatf("t4_wdata_%0d", i), mem_wdata, 32'hA5A5_A5A5);
      chk($sformatf("t4_readys_%0d", i), {ifu_req_ready, lsu_req_ready}, 0);
      chk($sformatf("t4_noresp_%0d", i), {ifu_resp_valid, lsu_resp_valid}, 0);
      tick();
    end
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    #1;
    chk("t4_hs_resp_ignored", lsu_resp_valid, 0);
    chk("t4_hs_valid",        mem_req_valid, 1);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("t4_resp_valid_drop", mem_req_valid, 0);
    chk("t4_resp_wait",       lsu_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0005;
    #1;
    chk("t4_lsu_resp", lsu_resp_valid, 1);
    chk("t4_rdata",    resp_rdata, 32'h0000_0005);
    tick();
    mem_resp_valid = 1'b0;
    ifu_req_valid  = 1'b0;
    lsu_req_valid  = 1'b0;
    lsu_wen        = 1'b0;
    tick();

    // ---------------- 5: reset during RESP ----------------
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0100;
    tick();
    ifu_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("t5_async_valid", mem_req_valid, 0);
    chk("t5_async_addr",  mem_addr, 0);
    tick();
    rst            = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h9999_9999;
    #1;
    chk("t5_late_resp",  {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("t5_late_rdata", resp_rdata, 0);
    chk("t5_mem_valid",  mem_req_valid, 0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("t5_mem_valid_after", mem_req_valid, 0);

`ifdef MEM_TIMEOUT_EN
    // ---------------- 6: timeout ----------------
    tick();
    mem_req_ready = 1'b0;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_5000;
    #1;
    chk("t6_lsu_ready", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      #1;
      chk($sformatf("t6_wait_%0d", k), lsu_resp_valid, 0);
      tick();
    end
    #1;
    chk("t6_resp_valid", lsu_resp_valid, 1);
    chk("t6_resp_err",   lsu_resp_err, 1);
    chk("t6_rdata",      resp_rdata, 32'hDEAD_BEEF);
    chk("t6_ifu_quiet",  ifu_resp_valid, 0);
    tick();
    #1;
    chk("t6_valid_forced", mem_req_valid, 0);
    mem_req_ready = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
